// File: rtl/uart32_link.sv
// uart32_link: 8N1 UART pair moving 32-bit words as four LSB-first bytes (TX: data[7:0] first).
// Latency: TX line starts the cycle after acceptance, 40 bit times per word; RX valid ~2 + 39.5 bits after first start edge.
// Backpressure: valid_in is taken only while ready_out=1; RX has none (valid_out is a one-cycle pulse).
// Optional build macro UART32_FRAMING_CHECK_EN: RX stop-bit check with frame_err pulse.
module uart32_link #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    output logic        ready_out,
    output logic        tx,
    output logic        tx_busy,
    input  logic        rx,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic        frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [1:0]    tx_byte_q, tx_byte_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic          tx_q, tx_d;

    // TX next-state: bit timing, bit/byte sequencing and the registered line value
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_word_d  = tx_word_q;
        case (tx_state_q)
            S_IDLE: begin
                if (valid_in) begin
                    tx_word_d  = data_in;
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_byte_d  = '0;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_byte_q != 2'd3) begin
                        tx_byte_d  = tx_byte_q + 1'b1;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
        endcase

        // Line value follows the next state so tx changes on the same edge as the FSM.
        // {byte, bit} is directly the word bit index because bytes go out LSB first.
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_word_q[{tx_byte_d, tx_bit_d}];
            default: tx_d = 1'b1;
        endcase
    end

    // TX state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_word_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_word_q  <= tx_word_d;
            tx_q       <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign ready_out = (tx_state_q == S_IDLE);
    assign tx_busy   = ~ready_out;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          sync1_q, sync2_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [1:0]    rx_byte_q, rx_byte_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [23:0]   rx_word_q, rx_word_d;
    logic [31:0]   data_out_q, data_out_d;
    logic          valid_q, valid_d;
`ifdef UART32_FRAMING_CHECK_EN
    logic          wait_high_q, wait_high_d;
    logic          frame_err_q, frame_err_d;
`endif

    // Two-flop synchronizer for the asynchronous serial input, preset to idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // RX next-state: start validation at half bit, mid-bit sampling, byte assembly into a word
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_shift_d = rx_shift_q;
        rx_word_d  = rx_word_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
`ifdef UART32_FRAMING_CHECK_EN
        wait_high_d = wait_high_q;
        frame_err_d = 1'b0;
`endif
        case (rx_state_q)
            S_IDLE: begin
`ifdef UART32_FRAMING_CHECK_EN
                // After a framing error the line must return high before a new start is trusted.
                if (wait_high_q) begin
                    if (sync2_q) begin
                        wait_high_d = 1'b0;
                    end
                end else if (!sync2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
`else
                if (!sync2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
`endif
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // A line that is high again at the start-bit centre was only a glitch.
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    // Leave at the stop-bit centre so the next start edge is not missed.
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
`ifdef UART32_FRAMING_CHECK_EN
                    if (!sync2_q) begin
                        rx_byte_d   = '0;
                        frame_err_d = 1'b1;
                        wait_high_d = 1'b1;
                    end else
`endif
                    begin
                        case (rx_byte_q)
                            2'd0: rx_word_d[7:0]   = rx_shift_q;
                            2'd1: rx_word_d[15:8]  = rx_shift_q;
                            2'd2: rx_word_d[23:16] = rx_shift_q;
                            default: begin
                                data_out_d = {rx_shift_q, rx_word_q};
                                valid_d    = 1'b1;
                            end
                        endcase
                        rx_byte_d = rx_byte_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // RX state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_shift_q <= '0;
            rx_word_q  <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_shift_q <= rx_shift_d;
            rx_word_q  <= rx_word_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_out_q;

`ifdef UART32_FRAMING_CHECK_EN
    // Framing-check state: re-arm flag and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_high_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wait_high_q <= wait_high_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart32_link.sv
// Bench for uart32_link at a reduced bit rate (16 clocks per bit) to keep runs short.
// Loopback and hand-driven rx; expected words and waveforms come from the frame rules.
module tb_uart32_link;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_HZ / BAUD;
    localparam int WORD_CYC = 40 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic        ready_out;
    logic        tx;
    logic        tx_busy;
    logic        rx_line;
    logic        valid_out;
    logic [31:0] data_out;
    logic        frame_err;
    logic        loop_en;
    logic        rx_drv;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart32_link #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out), .tx(tx), .tx_busy(tx_busy), .rx(rx_line),
        .valid_out(valid_out), .data_out(data_out), .frame_err(frame_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Received-word log and frame-error counter, written only by this monitor
    logic [31:0] rx_mem [0:63];
    int rx_cnt = 0;
    int fe_cnt = 0;
    always @(negedge clk) begin
        if (valid_out) begin
            rx_mem[rx_cnt % 64] <= data_out;
            rx_cnt <= rx_cnt + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    logic [31:0] exp_q[$];
    int rd_idx = 0;
    logic rec [0:WORD_CYC-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Compare everything received since the last call against the expected queue
    task automatic check_rx(input string tag);
        check({tag, " word count"}, 32'(rx_cnt - rd_idx), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rd_idx < rx_cnt) begin
            check({tag, " word"}, rx_mem[rd_idx % 64], exp_q.pop_front());
            rd_idx++;
        end
        rd_idx = rx_cnt;
        exp_q.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_out && n < 2 * WORD_CYC) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready timeout"}, 32'(ready_out), 32'd1);
    endtask

    // Present one word for a single cycle; entered and left on a falling edge
    task automatic send_word(input logic [31:0] w);
        wait_ready("send");
        valid_in = 1'b1;
        data_in  = w;
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = $urandom;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [31:0] plan_words [0:6];
        logic [31:0] w;
        int busy;
        int n_acc;
        int fe_base;
        logic ok;
        logic expb;

        plan_words[0] = 32'h0000_2710; plan_words[1] = 32'h0000_0032;
        plan_words[2] = 32'h0064_0000; plan_words[3] = 32'h0064_0000;
        plan_words[4] = 32'h0000_CCC0; plan_words[5] = 32'h0003_3333;
        plan_words[6] = 32'h0001_0000;

        rst = 1'b1; valid_in = 1'b0; data_in = '0; loop_en = 1'b1; rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset ready_out", 32'(ready_out), 32'd1);
        check("reset tx_busy", 32'(tx_busy), 32'd0);
        check("reset valid_out", 32'(valid_out), 32'd0);
        check("reset data_out", data_out, 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        fe_base = fe_cnt;

        // Loopback of the listed words followed by random words
        for (int i = 0; i < 11; i++) begin
            w = (i < 7) ? plan_words[i] : $urandom;
            send_word(w);
            exp_q.push_back(w);
            wait_ready("loopback");
            repeat (2) @(negedge clk);
            check_rx($sformatf("loopback %0d", i));
        end

        // Waveform check of one word on tx, with data_in wiggling while busy
        w = 32'hA5C3_0F12;
        valid_in = 1'b1;
        data_in  = w;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("start tx low", 32'(tx), 32'd0);
        check("start ready low", 32'(ready_out), 32'd0);
        check("start busy high", 32'(tx_busy), 32'd1);
        busy = 0;
        for (int k = 0; k < WORD_CYC + CPB; k++) begin
            @(negedge clk);
            data_in = $urandom;
            if (ready_out) break;
            if (k < WORD_CYC) rec[k] = tx;
            busy++;
        end
        check("busy cycles", 32'(busy), 32'(WORD_CYC));
        for (int b = 0; b < 40; b++) begin
            if (b % 10 == 0) expb = 1'b0;
            else if (b % 10 == 9) expb = 1'b1;
            else expb = w[8 * (b / 10) + (b % 10) - 1];
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (rec[b * CPB + c] !== expb) ok = 1'b0;
            end
            check($sformatf("frame bit %0d", b), 32'(ok), 32'd1);
        end
        exp_q.push_back(w);
        repeat (2) @(negedge clk);
        check_rx("frame word");

        // valid_in held high with changing data: one word per idle cycle
        n_acc = 0;
        for (int cyc = 0; cyc < 3 * (WORD_CYC + 1) + 20; cyc++) begin
            @(negedge clk);
            data_in  = $urandom;
            valid_in = 1'b1;
            if (ready_out) begin
                exp_q.push_back(data_in);
                n_acc++;
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        check("held accept count", 32'(n_acc),
              32'((3 * (WORD_CYC + 1) + 20 + WORD_CYC) / (WORD_CYC + 1)));
        wait_ready("held");
        repeat (2) @(negedge clk);
        check_rx("held valid");

        // Reset during the third byte: both sides abort, then recover
        send_word(32'hDEAD_BEEF);
        repeat (25 * CPB) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset tx", 32'(tx), 32'd1);
        check("midreset ready", 32'(ready_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (45 * CPB) @(negedge clk);
        check_rx("midreset no valid");
        send_word(32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        wait_ready("after reset");
        repeat (2) @(negedge clk);
        check_rx("after reset");

        // Short low glitch on an idle line
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (4) @(negedge clk);
        rx_drv = 1'b0;
        repeat ((3 * CPB) / 10) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check_rx("glitch no valid");
        w = $urandom;
        for (int j = 0; j < 4; j++) drive_byte(w[8 * j +: 8], 1'b1);
        exp_q.push_back(w);
        repeat (4) @(negedge clk);
        check_rx("after glitch");

        // Byte with a bad stop bit
        fe_base = fe_cnt;
        drive_byte(8'h3C, 1'b0);
        repeat (2 * CPB) @(negedge clk);
`ifdef UART32_FRAMING_CHECK_EN
        check("frame_err pulses", 32'(fe_cnt - fe_base), 32'd1);
        check_rx("bad stop no valid");
        drive_byte(8'h11, 1'b1); drive_byte(8'h22, 1'b1);
        drive_byte(8'h33, 1'b1); drive_byte(8'h44, 1'b1);
        exp_q.push_back(32'h4433_2211);
`else
        check("frame_err pulses", 32'(fe_cnt - fe_base), 32'd0);
        drive_byte(8'h11, 1'b1); drive_byte(8'h22, 1'b1); drive_byte(8'h33, 1'b1);
        exp_q.push_back(32'h3322_113C);
`endif
        repeat (4) @(negedge clk);
        check_rx("after bad stop");
        check("frame_err total", 32'(fe_cnt - fe_base),
`ifdef UART32_FRAMING_CHECK_EN
              32'd1);
`else
              32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart32_link.md
# uart32_link

Paired 32-bit UART transmitter and receiver carrying Q16.16 parameter words between host and FPGA over an 8N1 serial line. The TX half serializes one 32-bit word as four bytes, LSB byte first. The RX half reassembles four received bytes into one word and pulses a valid strobe. It sits at the host interface of the design, feeding parameter words in and results out.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT (localparam) = CLK_FREQ_HZ / BAUD_RATE, integer division; 868 at the defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_in  in  1  TX word request; accepted only when ready_out=1.
- data_in  in  32  TX word; captured on acceptance.
- ready_out  out  1  TX idle and able to accept a word.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  high while a word is being shifted out; equals ~ready_out.
- rx  in  1  serial input; asynchronous to clk.
- valid_out  out  1  one-cycle pulse when a full word has been received.
- data_out  out  32  last received word; held until the next word completes.
- frame_err  out  1  one-cycle pulse on a bad stop bit; tied 0 unless the configuration macro is defined.

## Operation
- Frame format: 8N1. One start bit (0), eight data bits LSB first, one stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- Word format: bytes are sent in the order data[7:0], [15:8], [23:16], [31:24]. Frames follow each other back-to-back with no idle gap.
- TX FSM states: IDLE, START, DATA, STOP. A byte index 0..3 tracks the current byte.
  - IDLE: tx=1 and ready_out=1. When valid_in=1, latch data_in and go to START with index 0.
  - START → DATA → STOP. After STOP, if index<3, increment the index and return to START; otherwise return to IDLE.
  - valid_in is ignored while busy. data_in changes during a transmission have no effect.
- RX: a 2-flop synchronizer drives rx into the FSM. RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 0 enters START.
  - START: at half a bit time, re-check the line. If it is 1, treat it as a glitch and return to IDLE.
  - DATA: sample each bit at mid-bit, every CLKS_PER_BIT cycles from the start-bit centre.
  - STOP: sample at mid-bit, store the byte into slot index, then return to IDLE. This leaves room to catch the next start edge.
  - After the fourth byte, update data_out and pulse valid_out for 1 cycle in the same cycle. Then reset the byte index to 0.
- There is no inter-byte timeout. A partial word persists until more bytes arrive or reset.

## Timing
- Reset values: tx=1, ready_out=1, tx_busy=0, valid_out=0, data_out=0, frame_err=0. Both FSMs go to IDLE, byte indices go to 0, and the synchronizer is preset to 1.
- TX: with valid_in=1 in IDLE at edge N, tx=0 (start bit) and ready_out=0 from the cycle after edge N.
  - The word occupies exactly 40·CLKS_PER_BIT cycles on tx.
  - ready_out returns to 1 in the cycle after the final stop bit ends.
- RX latency: valid_out pulses about 2 + 39.5·CLKS_PER_BIT cycles after the falling edge of the first start bit on rx.
- In loopback, valid_out precedes TX ready_out by about half a bit time.
- Reset mid-operation: a reset on any cycle aborts both sides immediately. tx goes high, any partial word is discarded, and no valid_out is issued.

## Configuration
- UART32_FRAMING_CHECK_EN defined:
  - An RX stop-bit sample of 0 discards the byte and clears the partial word (byte index back to 0).
  - frame_err pulses for 1 cycle and valid_out is not asserted for that word.
  - The FSM then returns to IDLE and waits for rx=1 before accepting a new start bit.
- Undefined: the stop bit is not checked, the byte is always stored, and frame_err is constant 0.

## Test plan
- Loopback (rx=tx), defaults: send the words 0x00002710, 0x00000032, 0x00640000, 0x00640000, 0x0000CCC0, 0x00033333, 0x00010000, one at a time. Expect exactly 7 valid_out pulses, with data_out equal to each sent word in order.
- Frame check: send 0xA5C3_0F12. The tx waveform must show bytes 0x12, 0x0F, 0xC3, 0xA5, LSB first, with each bit exactly 868 cycles, start=0 and stop=1. Total busy time must be 34720 cycles.
- Hold valid_in=1 continuously with data_in changing: exactly one word is sent per IDLE period, and the value sent is the one present at acceptance.
- Assert rst mid-way through byte 2 of a word: tx=1 and ready_out=1 on the next cycle. No valid_out follows. A following word 0x12345678 is received correctly.
- With UART32_FRAMING_CHECK_EN, drive rx by hand with a byte whose stop bit is 0: expect one frame_err pulse and no valid_out. The next 4 valid bytes then yield one correct word.
- Drive a 0.3-bit low glitch on rx while idle: no byte is captured and the next word is received correctly.
